grf_multiport: RTL and testbench

Parametrised general-purpose register file for the pipelined MIPS core. It has NUM_RD read ports and NUM_WR write ports, with an optional same-cycle write-to-read bypass. A per-register busy scoreboard lets the hazard unit stall on outstanding producers without comparing pipeline-stage addresses. It sits in the ID stage: reads feed the operand latches, and write ports come from WB, plus a second retire path for the multiply/divide unit.

---
 rtl/grf_pkg.sv | 27 ++
 rtl/grf_scoreboard.sv | 49 ++++
 rtl/grf_multiport.sv | 119 +++++++++++
 tb/tb_grf_multiport.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/grf_pkg.sv
// grf_pkg: shared definitions for the general-purpose register file.
//   DEFAULT_DATA_W / DEFAULT_ADDR_W : default register width and address width
//   REG_ZERO                        : hard-wired zero register address
//   get_field()                     : pulls port <idx> (width <w>) out of a
//                                     packed per-port vector
package grf_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int REG_ZERO       = 0;

    // Widest packed port vector and widest single field get_field() handles.
    localparam int MAX_VEC_W   = 1024;
    localparam int MAX_FIELD_W = 64;

    typedef logic [MAX_VEC_W-1:0]   vec_t;
    typedef logic [MAX_FIELD_W-1:0] field_t;

    // The caller widens its vector with vec_t'() and narrows the result back
    // to the field width with a size cast.
    function automatic field_t get_field(input vec_t vec, input int idx, input int w);
        vec_t shifted;
        shifted = vec >> (idx * w);
        return shifted[MAX_FIELD_W-1:0];
    endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// grf_scoreboard: one busy bit per register, tracking outstanding producers.
//   clk, reset : clock, synchronous active-high reset (clears every bit)
//   wr_en      : per-port write enables; an enabled write clears its address
//   wr_addr    : packed write addresses, port p at [p*ADDR_W +: ADDR_W]
//   iss_en     : a producer was issued for iss_addr; sets its bit
//   iss_addr   : destination of the issued producer
//   busy       : busy vector, bit r = register r
// A set and a clear on the same register in one cycle leave it set, since
// the issue belongs to a newer producer than the retiring write.
module grf_scoreboard
    import grf_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int NUM_WR = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [2**ADDR_W-1:0]     busy
);

    logic [2**ADDR_W-1:0] busy_next;

    always_comb begin
        busy_next = busy;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p]) begin
                busy_next[ADDR_W'(get_field(vec_t'(wr_addr), p, ADDR_W))] = 1'b0;
            end
        end
        // Applied after the clears so the issue wins a collision.
        if (iss_en) begin
            busy_next[iss_addr] = 1'b1;
        end
        busy_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/grf_multiport.sv
// grf_multiport: multi-port general-purpose register file with optional
// same-cycle write-to-read bypass and a per-register busy scoreboard.
//   clk, reset : clock, synchronous active-high reset
//   rd_addr    : packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data    : packed read data, combinational
//   rd_busy    : per read port, register has an outstanding producer
//   wr_en      : per-port write enables (higher port index wins collisions)
//   wr_addr    : packed write addresses
//   wr_data    : packed write data
//   iss_en     : mark iss_addr busy
//   iss_addr   : destination of the issued producer
module grf_multiport
    import grf_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wa  [NUM_WR];
    logic [DATA_W-1:0] wd  [NUM_WR];
    logic [NUM_WR-1:0] win;
    logic [DEPTH-1:0]  busy;

    // A port wins when it is enabled, not aimed at r0, and no higher-index
    // enabled port targets the same address. Winners therefore have distinct
    // addresses and can be committed without ordering concerns.
    for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
        logic shadowed;

        assign wa[p] = ADDR_W'(get_field(vec_t'(wr_addr), p, ADDR_W));
        assign wd[p] = DATA_W'(get_field(vec_t'(wr_data), p, DATA_W));

        always_comb begin
            shadowed = 1'b0;
            for (int q = p + 1; q < NUM_WR; q++) begin
                if (wr_en[q] && (wr_addr[q*ADDR_W +: ADDR_W] == wa[p])) begin
                    shadowed = 1'b1;
                end
            end
        end

        assign win[p] = wr_en[p] && (wa[p] != ADDR_W'(REG_ZERO)) && !shadowed;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (win[p]) begin
                    mem[wa[p]] <= wd[p];
                end
            end
        end
    end

    grf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy     (busy)
    );

    // Read ports. The forwarding scan runs low to high so the last match,
    // the highest-index port, is the one that lands, matching the commit.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] data;
        logic              hit;

        assign ra = ADDR_W'(get_field(vec_t'(rd_addr), i, ADDR_W));

        always_comb begin
            data = mem[ra];
            hit  = 1'b0;
            if ((BYPASS != 0) && (ra != ADDR_W'(REG_ZERO))) begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (wr_en[p] && (wa[p] == ra)) begin
                        data = wd[p];
                        hit  = 1'b1;
                    end
                end
            end
            if (ra == ADDR_W'(REG_ZERO)) begin
                data = '0;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = data;
        // A forwarded write means the operand is available now.
        assign rd_busy[i] = busy[ra] & ~hit;
    end

endmodule

// File: tb/tb_grf_multiport.sv
module tb_grf_multiport;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 3;
    localparam int NWR = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data_b1, rd_data_b0;
    logic [NRD-1:0]    rd_busy_b1, rd_busy_b0;
    logic [NWR-1:0]    wr_en;
    logic [NWR*AW-1:0] wr_addr;
    logic [NWR*DW-1:0] wr_data;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;

    always #5 clk = ~clk;

    grf_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(1)) dut_b1 (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b1), .rd_busy(rd_busy_b1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr)
    );

    grf_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(0)) dut_b0 (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b0), .rd_busy(rd_busy_b0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr)
    );

    typedef struct {
        string         tag;
        int            variant;
        bit            is_busy;
        int            port;
        logic [DW-1:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [DW-1:0]     m_mem [2**AW];
    logic [2**AW-1:0]  m_busy;

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] observe(input int variant, input bit is_busy, input int port);
        if (variant == 1) begin
            return is_busy ? DW'(rd_busy_b1[port]) : rd_data_b1[port*DW +: DW];
        end
        return is_busy ? DW'(rd_busy_b0[port]) : rd_data_b0[port*DW +: DW];
    endfunction

    task automatic expect_rd(input string tag, input int variant, input int port,
                             input logic [DW-1:0] data, input logic busy);
        exp_t e;
        e.variant = variant;
        e.port    = port;
        e.tag     = $sformatf("%s_b%0d_p%0d_data", tag, variant, port);
        e.is_busy = 1'b0;
        e.exp     = data;
        exp_q.push_back(e);
        e.tag     = $sformatf("%s_b%0d_p%0d_busy", tag, variant, port);
        e.is_busy = 1'b1;
        e.exp     = DW'(busy);
        exp_q.push_back(e);
    endtask

    task automatic expect_both(input string tag, input int port,
                               input logic [DW-1:0] data, input logic busy);
        for (int v = 0; v < 2; v++) expect_rd(tag, v, port, data, busy);
    endtask

    task automatic idle();
        reset    = 1'b0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
    endtask

    task automatic set_rd(input int i, input logic [AW-1:0] a);
        rd_addr[i*AW +: AW] = a;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en[p]            = 1'b1;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*DW +: DW] = d;
    endtask

    // Reference behaviour of one read port from the current model state.
    task automatic model_read(input int variant, input logic [AW-1:0] a,
                              output logic [DW-1:0] d, output logic b);
        logic fwd;
        fwd = 1'b0;
        d   = m_mem[a];
        if (variant == 1) begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p] && wr_addr[p*AW +: AW] == a) begin
                    d   = wr_data[p*DW +: DW];
                    fwd = 1'b1;
                end
            end
        end
        b = m_busy[a] && !fwd;
        if (a == '0) begin
            d = '0;
            b = 1'b0;
        end
    endtask

    task automatic model_update();
        logic [AW-1:0] a;
        if (reset) begin
            for (int r = 0; r < 2**AW; r++) m_mem[r] = '0;
            m_busy = '0;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                a = wr_addr[p*AW +: AW];
                if (wr_en[p] && a != '0) begin
                    m_mem[a]  = wr_data[p*DW +: DW];
                    m_busy[a] = 1'b0;
                end
            end
            if (iss_en && iss_addr != '0) m_busy[iss_addr] = 1'b1;
        end
    endtask

    // Inputs are set at posedge+1; outputs compared at the falling edge.
    task automatic step();
        exp_t e;
        #4;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, observe(e.variant, e.is_busy, e.port), e.exp);
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        logic [DW-1:0] md;
        logic          mb;

        idle();
        rd_addr = '0;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1; step();
        reset = 1'b1; step();

        idle(); set_rd(0, 5); set_rd(1, 5); set_rd(2, 0);
        expect_both("rst_init", 0, 32'h0, 1'b0);
        step();

        // Reset clears stored data, drops a write and an issue seen during it.
        idle(); set_wr(0, 5, 32'h1234); step();
        idle(); set_rd(0, 5);
        expect_both("w_r5", 0, 32'h1234, 1'b0);
        step();
        idle(); reset = 1'b1; set_wr(0, 6, 32'h777); iss_en = 1'b1; iss_addr = 5; step();
        idle(); set_rd(0, 5); set_rd(1, 6);
        expect_both("rst_clr", 0, 32'h0, 1'b0);
        expect_both("rst_wr_drop", 1, 32'h0, 1'b0);
        step();

        // Register 0 is hard-wired.
        idle(); set_wr(0, 0, 32'hFFFF_FFFF); iss_en = 1'b1; iss_addr = 0;
        for (int i = 0; i < NRD; i++) begin
            set_rd(i, 0);
            expect_both("r0_now", i, 32'h0, 1'b0);
        end
        step();
        idle();
        for (int i = 0; i < NRD; i++) expect_both("r0_next", i, 32'h0, 1'b0);
        step();

        // Write priority and bypass.
        idle(); set_wr(0, 7, 32'h1111_2222); step();
        idle(); set_wr(0, 7, 32'hAAAA_0000); set_wr(1, 7, 32'h0000_5555); set_rd(0, 7);
        expect_rd("prio_now", 1, 0, 32'h0000_5555, 1'b0);
        expect_rd("prio_now", 0, 0, 32'h1111_2222, 1'b0);
        step();
        idle(); set_rd(0, 7);
        expect_both("prio_next", 0, 32'h0000_5555, 1'b0);
        step();

        // Scoreboard set and clear.
        idle(); iss_en = 1'b1; iss_addr = 9; set_rd(0, 9);
        expect_both("iss_now", 0, 32'h0, 1'b0);
        step();
        idle(); set_rd(0, 9);
        expect_both("iss_next", 0, 32'h0, 1'b1);
        step();
        idle(); set_wr(1, 9, 32'h99); set_rd(0, 9);
        expect_rd("clr_now", 1, 0, 32'h99, 1'b0);
        expect_rd("clr_now", 0, 0, 32'h0, 1'b1);
        step();
        idle(); set_rd(0, 9);
        expect_both("clr_next", 0, 32'h99, 1'b0);
        step();

        // Set wins over clear on the same register.
        idle(); iss_en = 1'b1; iss_addr = 9; step();
        idle(); set_rd(0, 9);
        expect_both("busy_again", 0, 32'h99, 1'b1);
        step();
        idle(); iss_en = 1'b1; iss_addr = 9; set_wr(0, 9, 32'hABCD); set_rd(0, 9);
        expect_rd("coll_now", 1, 0, 32'hABCD, 1'b0);
        expect_rd("coll_now", 0, 0, 32'h99, 1'b1);
        step();
        idle(); set_rd(0, 9);
        expect_both("coll_next", 0, 32'hABCD, 1'b1);
        step();

        // All read ports aliased onto one register.
        idle(); set_wr(1, 12, 32'hDEAD_BEEF); step();
        idle();
        for (int i = 0; i < NRD; i++) begin
            set_rd(i, 12);
            expect_both("alias", i, 32'hDEAD_BEEF, 1'b0);
        end
        step();

        // Random traffic on a few addresses to provoke collisions.
        repeat (80) begin
            idle();
            reset = ($urandom_range(0, 24) == 0);
            for (int p = 0; p < NWR; p++) begin
                if ($urandom_range(0, 1) == 1) set_wr(p, AW'($urandom_range(0, 3)), $urandom);
            end
            iss_en   = ($urandom_range(0, 2) == 0);
            iss_addr = AW'($urandom_range(0, 3));
            for (int i = 0; i < NRD; i++) set_rd(i, AW'($urandom_range(0, 3)));
            for (int v = 0; v < 2; v++) begin
                for (int i = 0; i < NRD; i++) begin
                    model_read(v, rd_addr[i*AW +: AW], md, mb);
                    expect_rd("rand", v, i, md, mb);
                end
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
